// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
// - state_e : FSM state encodings (also exported on state_o for debug/LEDs)
// - StateW  : width of the state encoding
// - LossW   : width of the saturating lock-loss counter
// - RetryW  : width of the consecutive-timeout counter (MAX_RETRIES up to 15)
package pll_sup_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned LossW  = 8;
    localparam int unsigned RetryW = 4;

    typedef enum logic [StateW-1:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with configurable reset value.
// Ports:
//   clk   - destination clock
//   rst_n - synchronous, active-low reset (both flops load RESET_VAL)
//   d     - asynchronous input
//   q     - synchronised output, two clk edges of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL RESET pin, watches LOCK, and releases the
// downstream system reset only after lock has been continuously stable. Retries
// the PLL on lock timeout, re-sequences on loss of lock, and latches FAULT after
// MAX_RETRIES consecutive timeouts.
// Ports:
//   clkin       - reference clock, the only clock
//   rst_n       - synchronous, active-low reset
//   lock_i      - PLL LOCK, asynchronous; synchronised internally
//   pll_reset_o - 1 = hold PLL in reset
//   sys_rst_n_o - downstream reset, active-low; 1 only in RUN
//   locked_o    - 1 while in RUN
//   fault_o     - 1 while in FAULT (terminal until rst_n)
//   loss_cnt_o  - saturating count of lock losses seen in RUN
//   state_o     - current state encoding
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 13
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              lock_i,
    output logic              pll_reset_o,
    output logic              sys_rst_n_o,
    output logic              locked_o,
    output logic              fault_o,
    output logic [LossW-1:0]  loss_cnt_o,
    output logic [StateW-1:0] state_o
);

    localparam logic [CNT_W-1:0]  RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);
    localparam logic [LossW-1:0]  LossSat    = '1;

    logic lock_s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic [LossW-1:0]   loss_q, loss_d;
    logic               pll_reset_q, sys_rst_n_q, locked_q, fault_q;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (lock_i),
        .q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            StResetPll: begin
                if (timer_q == RstLast) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
            end
            StWaitLock: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_d = StStabilize;
                    timer_d = '0;
                end else if (timer_q == TimeoutLast) begin
                    retry_d = retry_q + 1'b1;
                    timer_d = '0;
                    state_d = (retry_d == RetryMax) ? StFault : StResetPll;
                end
            end
            StStabilize: begin
                // A glitch reopens the lock window without counting as a retry.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            StRun: begin
                timer_d = '0;
                if (!lock_s) begin
                    state_d = StResetPll;
                    if (loss_q != LossSat) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            StFault: begin
                timer_d = '0;
            end
            default: begin
                state_d = StResetPll;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // the state is entered.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q     <= StResetPll;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == StResetPll) || (state_d == StFault);
            sys_rst_n_q <= (state_d == StRun);
            locked_q    <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign locked_o    = locked_q;
    assign fault_o     = fault_q;
    assign loss_cnt_o  = loss_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_i = 1'b0;
    logic       pll_reset_o, sys_rst_n_o, locked_o, fault_o;
    logic [7:0] loss_cnt_o;
    logic [2:0] state_o;

    int tests = 0;
    int failed = 0;
    int n;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (16),
        .MAX_RETRIES    (2),
        .CNT_W          (13)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .lock_i      (lock_i),
        .pll_reset_o (pll_reset_o),
        .sys_rst_n_o (sys_rst_n_o),
        .locked_o    (locked_o),
        .fault_o     (fault_o),
        .loss_cnt_o  (loss_cnt_o),
        .state_o     (state_o)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until state_o == s; returns edges taken (max if bound hit).
    task automatic wait_state(input logic [2:0] s, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (state_o !== s && cnt < max);
    endtask

    task automatic wait_sys(input logic v, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (sys_rst_n_o !== v && cnt < max);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset_o), 1);
        check({tag, "_sys_rst_n"}, 32'(sys_rst_n_o), 0);
        check({tag, "_locked"}, 32'(locked_o), 0);
        check({tag, "_fault"}, 32'(fault_o), 0);
        check({tag, "_loss"}, 32'(loss_cnt_o), 0);
        check({tag, "_state"}, 32'(state_o), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-up reset and lock acquisition
        lock_i = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("pll_reset_held", 32'(pll_reset_o), 1);
        tick();
        check("pll_reset_released", 32'(pll_reset_o), 0);
        check("enter_wait_lock", 32'(state_o), 1);
        repeat (6) tick();
        lock_i = 1'b1;
        wait_sys(1'b1, 100, n);
        check("release_latency", 32'(n), 19);
        check("run_locked", 32'(locked_o), 1);
        check("run_state", 32'(state_o), 3);

        // Three lock losses in RUN
        for (int i = 1; i <= 3; i++) begin
            lock_i = 1'b0;
            wait_sys(1'b0, 20, n);
            check("loss_detect_edges", 32'(n), 3);
            check("loss_count", 32'(loss_cnt_o), 32'(i));
            check("loss_state", 32'(state_o), 0);
            lock_i = 1'b1;
            wait_state(3'd3, 200, n);
            check("reseq_run", 32'(locked_o), 1);
        end

        // Drive the loss counter to saturation
        for (int i = 4; i <= 300; i++) begin
            lock_i = 1'b0;
            wait_sys(1'b0, 20, n);
            lock_i = 1'b1;
            wait_state(3'd3, 200, n);
            if (i == 254) check("loss_254", 32'(loss_cnt_o), 254);
            if (i == 255) check("loss_255", 32'(loss_cnt_o), 255);
        end
        check("loss_saturated", 32'(loss_cnt_o), 255);
        check("sat_run_state", 32'(state_o), 3);

        // Reset while in RUN
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_in_run");
        rst_n = 1'b1;

        // Glitch during STABILIZE
        wait_state(3'd2, 50, n);
        check("reach_stabilize", 32'(state_o), 2);
        repeat (10) tick();
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        tick(); tick();
        check("glitch_to_wait_lock", 32'(state_o), 1);
        wait_sys(1'b1, 100, n);
        check("glitch_release_latency", 32'(n + 2), 19);

        // One timeout, then lock; retry is cleared in RUN
        lock_i = 1'b0;
        pulse_reset();
        wait_state(3'd1, 20, n);
        check("t5_rst_len", 32'(n), 4);
        wait_state(3'd0, 100, n);
        check("t5_timeout_len", 32'(n), 32);
        check("t5_no_fault", 32'(fault_o), 0);
        lock_i = 1'b1;
        wait_state(3'd3, 200, n);
        check("t5_run", 32'(locked_o), 1);
        lock_i = 1'b0;
        wait_state(3'd0, 20, n);
        check("t5_loss_edges", 32'(n), 3);
        wait_state(3'd1, 20, n);
        check("t5_rst_len2", 32'(n), 4);
        wait_state(3'd0, 100, n);
        check("t5_single_timeout", 32'(n), 32);
        check("t5_still_no_fault", 32'(fault_o), 0);
        check("t5_pll_reset", 32'(pll_reset_o), 1);

        // Lock never rises -> FAULT
        pulse_reset();
        wait_state(3'd1, 20, n);
        check("f_rst_len1", 32'(n), 4);
        wait_state(3'd0, 100, n);
        check("f_timeout1", 32'(n), 32);
        check("f_retry_pll_reset", 32'(pll_reset_o), 1);
        wait_state(3'd1, 20, n);
        check("f_rst_len2", 32'(n), 4);
        n = 0;
        while (state_o === 3'd1 && n < 100) begin
            tick();
            n++;
        end
        check("f_timeout2", 32'(n), 32);
        check("f_state", 32'(state_o), 4);
        check("f_fault", 32'(fault_o), 1);
        check("f_pll_reset", 32'(pll_reset_o), 1);
        check("f_sys_rst_n", 32'(sys_rst_n_o), 0);
        lock_i = 1'b1;
        repeat (40) tick();
        check("f_sticky_state", 32'(state_o), 4);
        check("f_sticky_fault", 32'(fault_o), 1);
        check("f_sticky_locked", 32'(locked_o), 0);

        // Reset while in FAULT
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_in_fault");
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
